// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and Status/Cause field positions.
// The pipeline exception-stage blocks use the same exception codes.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
        return (bd ? pc - 32'd4 : pc) & ~32'd3;
    endfunction

endpackage

// File: rtl/cp0_req.sv
// Combinational exception/interrupt arbitration for CP0; the interrupt wins over
// a simultaneous exception and everything is masked while EXL is set or in reset.
module cp0_req
    import cp0_pkg::*;
(
    input  logic       active,
    input  logic [4:0] exccode,
    input  logic [5:0] hwint,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    output logic       int_req,
    output logic       exc_req,
    output logic       req,
    output logic [4:0] exccode_sel
);

    assign int_req     = active & (|(hwint & im)) & ie & ~exl;
    assign exc_req     = active & (exccode != EXC_INT) & ~exl;
    assign req         = int_req | exc_req;
    assign exccode_sel = int_req ? EXC_INT : exccode;

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: Status/Cause/EPC/PRId, exception entry and eret.
// Define CP0_BADVADDR_EN to add the BadVAddr register (reg 8).
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0000_2020,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  exccode_m,
    input  logic        bd_m,
    input  logic [31:0] pc_m,
    input  logic [31:0] badaddr_m,
    input  logic [5:0]  hwint,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    input  logic        eret,
    output logic [31:0] dout,
    output logic        req,
    output logic [31:0] epc,
    output logic [31:0] handler_pc
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc_q;
    logic        int_req;
    logic        exc_req;
    logic [4:0]  exccode_sel;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] badvaddr_val;

    cp0_req u_req (
        .active      (reset_n),
        .exccode     (exccode_m),
        .hwint       (hwint),
        .im          (im),
        .ie          (ie),
        .exl         (exl),
        .int_req     (int_req),
        .exc_req     (exc_req),
        .req         (req),
        .exccode_sel (exccode_sel)
    );

    // Exception entry takes precedence over eret and drops any mtc0 in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc_q    <= '0;
        end else begin
            ip <= hwint;
            if (req) begin
                exl      <= 1'b1;
                exc_code <= exccode_sel;
                bd       <= bd_m;
                epc_q    <= epc_target(pc_m, bd_m);
            end else begin
                if (eret)
                    exl <= 1'b0;
                if (we && addr == REG_SR) begin
                    im  <= din[SR_IM_HI:SR_IM_LO];
                    exl <= din[SR_EXL];
                    ie  <= din[SR_IE];
                end
                if (we && addr == REG_EPC)
                    epc_q <= {din[31:2], 2'b00};
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            badvaddr_q <= '0;
        else if (exc_req && !int_req && (exccode_m == EXC_ADEL || exccode_m == EXC_ADES))
            badvaddr_q <= badaddr_m;
    end

    assign badvaddr_val = badvaddr_q;
`else
    logic unused_badaddr;
    assign unused_badaddr = ^badaddr_m;
    assign badvaddr_val   = '0;
`endif

    always_comb begin
        sr_val                     = '0;
        sr_val[SR_IM_HI:SR_IM_LO]  = im;
        sr_val[SR_EXL]             = exl;
        sr_val[SR_IE]              = ie;
        cause_val                         = '0;
        cause_val[CAUSE_BD]               = bd;
        cause_val[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
        cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
    end

    always_comb begin
        case (addr)
            REG_BADVADDR: dout = badvaddr_val;
            REG_SR:       dout = sr_val;
            REG_CAUSE:    dout = cause_val;
            REG_EPC:      dout = epc_q;
            REG_PRID:     dout = PRID_VAL;
            default:      dout = '0;
        endcase
    end

    assign epc        = epc_q;
    assign handler_pc = HANDLER_PC;

endmodule
